// File: rtl/n64_audio_ser_tx.sv
// n64_audio_ser_tx
// Serializer for the N64 audio DAC link (BU9480F format). It accepts 16-bit
// left/right sample pairs over a valid/ready handshake and shifts them out
// MSB first as ASCLK/ASDATA/ALRCLK. It serves as an internal test-tone or
// loopback source ahead of the APU, and as a stimulus model for the APU
// input path.
//
// Parameters
//   SCLK_HALF      AMCLK cycles per ASCLK half-period (2..255). One frame
//                  lasts 64*SCLK_HALF cycles.
//   UNDERRUN_ZERO  0: an underrun resends the last frame. 1: it sends zeros.
//
// Ports
//   AMCLK_i         clock; all logic runs on its rising edge
//   nARST           asynchronous active-low reset
//   enable_i        1 = stream frames; 0 = finish the current frame, then idle
//   sample_left_i   left sample, two's complement
//   sample_right_i  right sample, two's complement
//   sample_valid_i  the source presents a sample pair
//   sample_ready_o  holding buffer empty; a transfer happens on valid & ready
//   ASCLK_o         bit clock; the receiver samples ASDATA on its rising edge
//   ASDATA_o        serial data, MSB first; changes on ASCLK falling edges
//   ALRCLK_o        1 = left word, 0 = right word; a rising edge starts a frame
//   underrun_o      1-cycle pulse: a frame started with no sample available
module n64_audio_ser_tx #(
  parameter int SCLK_HALF     = 8,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic        AMCLK_i,
  input  logic        nARST,
  input  logic        enable_i,
  input  logic [15:0] sample_left_i,
  input  logic [15:0] sample_right_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic        ASCLK_o,
  output logic        ASDATA_o,
  output logic        ALRCLK_o,
  output logic        underrun_o
);

  localparam logic [7:0] DIV_TC = 8'(SCLK_HALF - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;
  logic        lrclk_q, lrclk_d;
  logic        underrun_q, underrun_d;
  logic        empty_q, empty_d;
  logic [31:0] last_q, last_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] frame_q, frame_d;

  // Event decode for the current cycle.
  logic        tc;
  logic        fall_evt;
  logic        boundary;
  logic        stop;
  logic        from_buf;
  logic        bypass;
  logic        starve;
  logic        load;
  logic        xfer;
  logic [31:0] new_word;

  always_comb begin
    tc       = (state_q == RUN) && (div_cnt_q == DIV_TC);
    // A falling edge is due whenever the divider wraps while ASCLK is high.
    fall_evt = tc && sclk_q;
    boundary = fall_evt && (bit_cnt_q == 5'd0);
    stop     = boundary && !enable_i;
    from_buf = boundary && enable_i && !empty_q;
    bypass   = boundary && enable_i && empty_q && sample_valid_i;
    starve   = boundary && enable_i && empty_q && !sample_valid_i;
    load     = from_buf || bypass || starve;
    // A bypass pair goes straight into the frame, so it never enters the buffer.
    xfer     = sample_valid_i && empty_q && !bypass;
    if (from_buf) begin
      new_word = buf_q;
    end else if (bypass) begin
      new_word = {sample_left_i, sample_right_i};
    end else if (UNDERRUN_ZERO) begin
      new_word = 32'h0;
    end else begin
      new_word = last_q;
    end
  end

  // State register
  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = RUN;
      RUN:     if (stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    sdata_d    = sdata_q;
    lrclk_d    = lrclk_q;
    underrun_d = starve;
    empty_d    = empty_q;
    last_d     = last_q;
    buf_d      = buf_q;
    frame_d    = frame_q;

    if (state_q == IDLE) begin
      div_cnt_d = 8'd0;
    end else if (tc) begin
      div_cnt_d = 8'd0;
    end else begin
      div_cnt_d = div_cnt_q + 8'd1;
    end

    if (stop) begin
      // Leaving for IDLE: the closing falling edge is suppressed so ASCLK
      // rests high, and the line returns to its reset levels.
      bit_cnt_d = 5'd0;
      sdata_d   = 1'b0;
      lrclk_d   = 1'b0;
    end else if (fall_evt) begin
      sclk_d    = 1'b0;
      bit_cnt_d = bit_cnt_q + 5'd1;
      lrclk_d   = ~bit_cnt_q[4];
      if (boundary) begin
        sdata_d = new_word[31];
      end else begin
        sdata_d = frame_q[5'd31 - bit_cnt_q];
      end
    end else if (tc) begin
      sclk_d = 1'b1;
    end

    if (load) begin
      frame_d = new_word;
      last_d  = new_word;
    end

    if (from_buf) begin
      empty_d = 1'b1;
    end else if (xfer) begin
      empty_d = 1'b0;
      buf_d   = {sample_left_i, sample_right_i};
    end
  end

  // Control and output registers
  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      div_cnt_q  <= 8'd0;
      bit_cnt_q  <= 5'd0;
      sclk_q     <= 1'b1;
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
      empty_q    <= 1'b1;
      last_q     <= 32'h0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      lrclk_q    <= lrclk_d;
      underrun_q <= underrun_d;
      empty_q    <= empty_d;
      last_q     <= last_d;
    end
  end

  // Sample storage; contents are qualified by empty_q and the frame load,
  // so they need no reset.
  always_ff @(posedge AMCLK_i) begin
    buf_q   <= buf_d;
    frame_q <= frame_d;
  end

  assign sample_ready_o = empty_q;
  assign ASCLK_o        = sclk_q;
  assign ASDATA_o       = sdata_q;
  assign ALRCLK_o       = lrclk_q;
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_n64_audio_ser_tx.sv
// Testbench for n64_audio_ser_tx: a serial receiver model deserializes the
// DAC stream and compares each frame against a scoreboard of pushed pairs.
module tb_n64_audio_ser_tx;

  localparam int S  = 8;
  localparam bit UZ = 1'b0;

  logic        AMCLK_i = 1'b0;
  logic        nARST = 1'b0;
  logic        enable_i = 1'b0;
  logic [15:0] sample_left_i = 16'h0;
  logic [15:0] sample_right_i = 16'h0;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic        ASCLK_o;
  logic        ASDATA_o;
  logic        ALRCLK_o;
  logic        underrun_o;

  n64_audio_ser_tx #(.SCLK_HALF(S), .UNDERRUN_ZERO(UZ)) dut (
    .AMCLK_i       (AMCLK_i),
    .nARST         (nARST),
    .enable_i      (enable_i),
    .sample_left_i (sample_left_i),
    .sample_right_i(sample_right_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o),
    .ASCLK_o       (ASCLK_o),
    .ASDATA_o      (ASDATA_o),
    .ALRCLK_o      (ALRCLK_o),
    .underrun_o    (underrun_o)
  );

  always #5 AMCLK_i = ~AMCLK_i;

  int          nvec = 0;
  int          nmis = 0;
  int          n_under = 0;
  int          frames_done = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_model = 32'h0;

  // Receiver model / scoreboard
  initial begin
    logic        prev_sclk;
    logic        prev_alr;
    logic        rx_act;
    int          rx_cnt;
    logic [31:0] rx_word;
    logic [31:0] exp_cur;
    logic        exp_under;
    prev_sclk = 1'b1;
    prev_alr  = 1'b0;
    rx_act    = 1'b0;
    rx_cnt    = 0;
    rx_word   = 32'h0;
    exp_cur   = 32'h0;
    forever begin
      @(negedge AMCLK_i);
      if (!nARST) begin
        prev_sclk = 1'b1;
        prev_alr  = 1'b0;
        rx_act    = 1'b0;
      end else begin
        if (underrun_o === 1'b1) n_under++;
        if (ALRCLK_o === 1'b1 && !prev_alr) begin
          exp_under = (exp_q.size() == 0);
          if (!exp_under) exp_cur = exp_q.pop_front();
          else exp_cur = UZ ? 32'h0 : last_model;
          last_model = exp_cur;
          nvec++;
          if (underrun_o !== exp_under) begin
            nmis++;
            $display("FAIL frame_underrun: underrun_o=%b required %b", underrun_o, exp_under);
          end
          rx_act = 1'b1;
          rx_cnt = 0;
        end
        if (!prev_sclk && ASCLK_o === 1'b1 && rx_act) begin
          nvec++;
          if (ALRCLK_o !== (rx_cnt < 16)) begin
            nmis++;
            $display("FAIL lrclk_bit%0d: ALRCLK=%b required %b", rx_cnt, ALRCLK_o, (rx_cnt < 16));
          end
          rx_word = {rx_word[30:0], ASDATA_o};
          rx_cnt++;
          if (rx_cnt == 32) begin
            rx_act = 1'b0;
            frames_done++;
            nvec++;
            if (rx_word !== exp_cur) begin
              nmis++;
              $display("FAIL frame_data: got %08h required %08h", rx_word, exp_cur);
            end
          end
        end
        prev_sclk = ASCLK_o;
        prev_alr  = ALRCLK_o;
      end
    end
  end

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    bit ok;
    ok = 1'b0;
    sample_left_i  = l;
    sample_right_i = r;
    sample_valid_i = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (sample_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge AMCLK_i);
    end
    if (!ok) begin
      nvec++;
      nmis++;
      $display("FAIL push_timeout: ready=%b required 1", sample_ready_o);
      sample_valid_i = 1'b0;
    end else begin
      @(posedge AMCLK_i);
      #1 exp_q.push_back({l, r});
      @(negedge AMCLK_i);
      sample_valid_i = 1'b0;
    end
  endtask

  task automatic wait_rise(output int n);
    logic p;
    p = ALRCLK_o;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge AMCLK_i);
      n++;
      if (ALRCLK_o === 1'b1 && !p) return;
      p = ALRCLK_o;
    end
    nvec++;
    nmis++;
    $display("FAIL rise_timeout: no ALRCLK rise within 2000 cycles");
    n = -1;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 3000; i++) begin
      @(negedge AMCLK_i);
      #1;
      if (frames_done >= target) return;
    end
    nvec++;
    nmis++;
    $display("FAIL frame_timeout: frames_done=%0d required %0d", frames_done, target);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge AMCLK_i);
    nvec += 5;
    if (ASCLK_o !== 1'b1)        begin nmis++; $display("FAIL rst_asclk: got %b required 1", ASCLK_o); end
    if (ASDATA_o !== 1'b0)       begin nmis++; $display("FAIL rst_asdata: got %b required 0", ASDATA_o); end
    if (ALRCLK_o !== 1'b0)       begin nmis++; $display("FAIL rst_alrclk: got %b required 0", ALRCLK_o); end
    if (sample_ready_o !== 1'b1) begin nmis++; $display("FAIL rst_ready: got %b required 1", sample_ready_o); end
    if (underrun_o !== 1'b0)     begin nmis++; $display("FAIL rst_underrun: got %b required 0", underrun_o); end
    nARST = 1'b1;
    repeat (2) @(negedge AMCLK_i);
  endtask

  task automatic test_first_frame();
    int n;
    push_pair(16'hA5C3, 16'h0F01);
    nvec++;
    if (sample_ready_o !== 1'b0) begin nmis++; $display("FAIL idle_buffered_ready: got %b required 0", sample_ready_o); end
    enable_i = 1'b1;
    wait_rise(n);
    nvec += 3;
    if (n != S + 1)          begin nmis++; $display("FAIL first_rise_latency: got %0d required %0d", n, S + 1); end
    if (ASCLK_o !== 1'b0)    begin nmis++; $display("FAIL first_fall_asclk: got %b required 0", ASCLK_o); end
    if (ASDATA_o !== 1'b1)   begin nmis++; $display("FAIL first_msb: got %b required 1", ASDATA_o); end
    wait_rise(n);
    nvec++;
    if (n != 64 * S)         begin nmis++; $display("FAIL frame_period: got %0d required %0d", n, 64 * S); end
  endtask

  task automatic test_back_to_back();
    int u0;
    bit first;
    first = 1'b1;
    u0 = 0;
    for (int k = 0; k < 6; k++) begin
      push_pair(16'h1000 + 16'(k), 16'hE000 - 16'(k));
      if (first) begin
        u0 = n_under;
        first = 1'b0;
      end
      nvec++;
      if (sample_ready_o !== 1'b0) begin nmis++; $display("FAIL b2b_ready_after_xfer%0d: got %b required 0", k, sample_ready_o); end
    end
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(negedge AMCLK_i);
      #1;
    end
    nvec++;
    if (n_under != u0) begin nmis++; $display("FAIL b2b_underruns: got %0d required 0", n_under - u0); end
  endtask

  task automatic test_starve_bypass();
    int n;
    int u0;
    push_pair(16'h7FFF, 16'h8000);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(negedge AMCLK_i);
      #1;
    end
    u0 = n_under;
    wait_rise(n);
    wait_rise(n);
    #1;
    nvec++;
    if (n_under - u0 != 2) begin nmis++; $display("FAIL starve_underruns: got %0d required 2", n_under - u0); end
    // Present a pair exactly on the next boundary cycle: it must bypass.
    repeat (64 * S - 1) @(negedge AMCLK_i);
    push_pair(16'hC234, 16'h5678);
    nvec += 4;
    if (ALRCLK_o !== 1'b1)       begin nmis++; $display("FAIL bypass_alrclk: got %b required 1", ALRCLK_o); end
    if (ASDATA_o !== 1'b1)       begin nmis++; $display("FAIL bypass_msb: got %b required 1", ASDATA_o); end
    if (sample_ready_o !== 1'b1) begin nmis++; $display("FAIL bypass_ready: got %b required 1", sample_ready_o); end
    if (underrun_o !== 1'b0)     begin nmis++; $display("FAIL bypass_underrun: got %b required 0", underrun_o); end
  endtask

  task automatic test_enable_drop();
    int n;
    int f0;
    int edges;
    logic ps;
    push_pair(16'hAAAA, 16'h5555);
    wait_rise(n);
    f0 = frames_done;
    repeat (4 * 2 * S + 2) @(negedge AMCLK_i);
    enable_i = 1'b0;
    wait_frames(f0 + 1);
    repeat (3 * S) @(negedge AMCLK_i);
    nvec += 3;
    if (ASCLK_o !== 1'b1)  begin nmis++; $display("FAIL drop_asclk: got %b required 1", ASCLK_o); end
    if (ALRCLK_o !== 1'b0) begin nmis++; $display("FAIL drop_alrclk: got %b required 0", ALRCLK_o); end
    if (ASDATA_o !== 1'b0) begin nmis++; $display("FAIL drop_asdata: got %b required 0", ASDATA_o); end
    edges = 0;
    ps = ASCLK_o;
    for (int i = 0; i < 300; i++) begin
      @(negedge AMCLK_i);
      if (ASCLK_o !== ps || ALRCLK_o !== 1'b0 || underrun_o !== 1'b0) edges++;
      ps = ASCLK_o;
    end
    nvec++;
    if (edges != 0) begin nmis++; $display("FAIL drop_idle_activity: got %0d required 0", edges); end
    push_pair(16'h0123, 16'hFEDC);
    nvec++;
    if (sample_ready_o !== 1'b0) begin nmis++; $display("FAIL drop_idle_buffer: got %b required 0", sample_ready_o); end
    enable_i = 1'b1;
    wait_rise(n);
    nvec++;
    if (n != S + 1) begin nmis++; $display("FAIL reenable_latency: got %0d required %0d", n, S + 1); end
    f0 = frames_done;
    wait_frames(f0 + 1);
  endtask

  task automatic test_reset_mid();
    int n;
    int f0;
    push_pair(16'h3C3C, 16'hC3C3);
    wait_rise(n);
    repeat (40) @(negedge AMCLK_i);
    push_pair(16'h1111, 16'h2222);
    #2 nARST = 1'b0;
    #1;
    nvec += 4;
    if (ASCLK_o !== 1'b1)        begin nmis++; $display("FAIL midrst_asclk: got %b required 1", ASCLK_o); end
    if (ASDATA_o !== 1'b0)       begin nmis++; $display("FAIL midrst_asdata: got %b required 0", ASDATA_o); end
    if (ALRCLK_o !== 1'b0)       begin nmis++; $display("FAIL midrst_alrclk: got %b required 0", ALRCLK_o); end
    if (sample_ready_o !== 1'b1) begin nmis++; $display("FAIL midrst_ready: got %b required 1", sample_ready_o); end
    exp_q.delete();
    last_model = 32'h0;
    repeat (3) @(negedge AMCLK_i);
    nARST = 1'b1;
    push_pair(16'h8001, 16'h7FFE);
    wait_rise(n);
    nvec++;
    if (n < 1) begin nmis++; $display("FAIL midrst_restart: got %0d required a rise", n); end
    f0 = frames_done;
    wait_frames(f0 + 1);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_starve_bypass();
    test_enable_drop();
    test_reset_mid();
    repeat (4) @(negedge AMCLK_i);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
